// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//   state_t    : FSM encoding (IDLE, RUN, FIN, DONE)
//   FLAG_*     : NZCV bit positions, same ordering as the flag register
//   bpc_legal  : elaboration-time legality check for bits-per-cycle
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // BPC must be 1, 2 or 4 and divide the operand width.
    function automatic bit bpc_legal(input int unsigned width, input int unsigned bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Execute-stage <-> multiplier bus.
//   master : execute stage (drives operands/controls, receives results)
//   slave  : mul_unit
//   StartE/FlushE/AccumE/LongE/SignedE : controls
//   SrcAE/SrcBE/AccE/FlagsIn            : operands and current NZCV
//   Busy/Done/ResultLo/ResultHi/MulFlags: status and results
interface mul_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             StartE;
    logic             FlushE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] AccE;
    logic             AccumE;
    logic             LongE;
    logic             SignedE;
    logic [3:0]       FlagsIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic [3:0]       MulFlags;

    modport master (
        output StartE, FlushE, SrcAE, SrcBE, AccE, AccumE, LongE, SignedE, FlagsIn,
        input  Busy, Done, ResultLo, ResultHi, MulFlags
    );

    modport slave (
        input  StartE, FlushE, SrcAE, SrcBE, AccE, AccumE, LongE, SignedE, FlagsIn,
        output Busy, Done, ResultLo, ResultHi, MulFlags
    );
endinterface

// File: rtl/mul_step.sv
// One combinational shift-add slice of the iterative multiplier.
// The partial product is accumulated in its upper half and shifted right by
// BPC each step, so after WIDTH/BPC steps it holds the exact product.
//   i_pp : current 2*WIDTH partial product
//   i_a  : multiplicand
//   i_b  : next BPC multiplier bits (LSB first)
//   o_pp : next partial product
module mul_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic [2*WIDTH-1:0] i_pp,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [BPC-1:0]     i_b,
    output logic [2*WIDTH-1:0] o_pp
);
    localparam int unsigned PW = WIDTH + BPC;
    localparam int unsigned SW = 2*WIDTH + BPC;

    logic [PW-1:0] w_part;
    logic [SW-1:0] w_sum;

    assign w_part = PW'(i_a) * PW'(i_b);
    // Low BPC bits dropped here are always zero until the final step.
    assign w_sum  = SW'(i_pp) + {w_part, {WIDTH{1'b0}}};
    assign o_pp   = w_sum[SW-1:BPC];
endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA execute-stage multiplier and NZCV producer.
// Optional long multiply (UMULL/SMULL) enabled by defining MUL_LONG_EN.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mul_unit_if.slave (controls, operands, Busy/Done, results, flags)
// Timing: Start accepted at edge 0, Busy for WIDTH/BPC+1 cycles, then a
// one-cycle Done with ResultLo/ResultHi/MulFlags updated on entry to DONE.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input logic       clk,
    input logic       reset,
    mul_unit_if.slave bus
);
    localparam int unsigned N     = WIDTH / BPC;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    if (!bpc_legal(WIDTH, BPC)) begin : g_bpc_check
        $error("mul_unit: BPC must be 1, 2 or 4 and divide WIDTH");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_start;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_accum;
    logic [1:0]       r_cv;
    logic [PW-1:0]    r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [3:0]       r_flags;

    logic [PW-1:0]    w_step;
    logic [WIDTH-1:0] w_a_lat;
    logic [WIDTH-1:0] w_b_lat;
    logic [WIDTH-1:0] w_fin_lo;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_n;
    logic             w_fin_z;
    logic [3:0]       w_fin_flags;

`ifdef MUL_LONG_EN
    logic             r_long;
    logic             r_neg;
    logic             w_signed;
    logic [PW-1:0]    w_full;
    logic             w_unused_flags;

    assign w_unused_flags = ^bus.FlagsIn[3:2];
`else
    logic             w_unused_ok;

    // Long-multiply controls and the upper product half have no consumer here.
    assign w_unused_ok = ^{bus.LongE, bus.SignedE, bus.FlagsIn[3:2], r_prod[PW-1:WIDTH]};
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush always wins over start.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.StartE && !bus.FlushE) begin
                    w_next  = ST_RUN;
                    w_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.FlushE) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == CNT_W'(N - 1)) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next = bus.FlushE ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (bus.StartE && !bus.FlushE) begin
                    w_next  = ST_RUN;
                    w_start = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand conditioning at latch time: signed long ops run on magnitudes.
`ifdef MUL_LONG_EN
    assign w_signed = bus.LongE && bus.SignedE;
    assign w_a_lat  = (w_signed && bus.SrcAE[WIDTH-1]) ? (~bus.SrcAE + WIDTH'(1)) : bus.SrcAE;
    assign w_b_lat  = (w_signed && bus.SrcBE[WIDTH-1]) ? (~bus.SrcBE + WIDTH'(1)) : bus.SrcBE;
`else
    assign w_a_lat  = bus.SrcAE;
    assign w_b_lat  = bus.SrcBE;
`endif

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .i_pp (r_prod),
        .i_a  (r_a),
        .i_b  (r_b[BPC-1:0]),
        .o_pp (w_step)
    );

    // Final result and flags, committed on the FIN -> DONE edge.
    always_comb begin
        w_fin_lo = r_prod[WIDTH-1:0] + (r_accum ? r_acc : '0);
        w_fin_hi = '0;
        w_fin_n  = w_fin_lo[WIDTH-1];
        w_fin_z  = (w_fin_lo == '0);
`ifdef MUL_LONG_EN
        w_full   = r_neg ? (~r_prod + PW'(1)) : r_prod;
        if (r_long) begin
            w_fin_lo = w_full[WIDTH-1:0];
            w_fin_hi = w_full[PW-1:WIDTH];
            w_fin_n  = w_full[PW-1];
            w_fin_z  = (w_full == '0);
        end
`endif
        // NZCV ordering; C and V pass through unchanged from the latched flags.
        w_fin_flags = {w_fin_n, w_fin_z, r_cv};
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_accum <= 1'b0;
            r_cv    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_flags <= '0;
`ifdef MUL_LONG_EN
            r_long  <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            r_busy <= (w_next == ST_RUN) || (w_next == ST_FIN);
            r_done <= (w_next == ST_DONE);

            if (w_start) begin
                r_a     <= w_a_lat;
                r_b     <= w_b_lat;
                r_acc   <= bus.AccE;
                r_accum <= bus.AccumE;
                r_cv    <= bus.FlagsIn[1:0];
                r_prod  <= '0;
                r_cnt   <= '0;
`ifdef MUL_LONG_EN
                r_long  <= bus.LongE;
                r_neg   <= w_signed && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
`endif
            end else if (r_state == ST_RUN && !bus.FlushE) begin
                r_prod <= w_step;
                r_b    <= r_b >> BPC;
                r_cnt  <= r_cnt + CNT_W'(1);
            end

            if (w_next == ST_DONE) begin
                r_lo    <= w_fin_lo;
                r_hi    <= w_fin_hi;
                r_flags <= w_fin_flags;
            end
        end
    end

    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.ResultLo = r_lo;
    assign bus.ResultHi = r_hi;
    assign bus.MulFlags = r_flags;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit (WIDTH=32, BPC=1): table-driven vectors
// through a result scoreboard, plus flush, ignored-start, back-to-back and
// mid-operation reset sequences. Long-multiply vectors follow MUL_LONG_EN.
module tb_mul_unit;
    import mul_pkg::*;

    localparam int unsigned W     = 32;
    localparam int          NBUSY = 33;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic        accum;
        logic        lng;
        logic        sgn;
        logic [3:0]  fl;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  mf;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  mf;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   done_cnt;
    logic [31:0] last_lo;
    exp_t sb[$];
    vec_t tbl[$];

    mul_unit_if #(.WIDTH(W)) bus ();

    mul_unit #(.WIDTH(W), .BPC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pops one expected result.
    always @(negedge clk) begin
        if (!reset && bus.Done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                chk("result_lo", 64'(bus.ResultLo), 64'(e.lo));
                chk("result_hi", 64'(bus.ResultHi), 64'(e.hi));
                chk("mul_flags", 64'(bus.MulFlags), 64'(e.mf));
                last_lo = e.lo;
            end
        end
    end

    task automatic drive_start(input vec_t v);
        bus.SrcAE   = v.a;
        bus.SrcBE   = v.b;
        bus.AccE    = v.acc;
        bus.AccumE  = v.accum;
        bus.LongE   = v.lng;
        bus.SignedE = v.sgn;
        bus.FlagsIn = v.fl;
        bus.StartE  = 1'b1;
        @(posedge clk); #1;
        bus.StartE  = 1'b0;
    endtask

    task automatic start_op(input vec_t v);
        exp_t e;
        e.lo = v.lo;
        e.hi = v.hi;
        e.mf = v.mf;
        sb.push_back(e);
        drive_start(v);
    endtask

    // Counts Busy samples until Done; bounded so a stuck DUT still finishes.
    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.Busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] acc, input logic accum,
                                input logic lng, input logic sgn, input logic [3:0] fl,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input logic [3:0] mf);
        vec_t v;
        v.a = a; v.b = b; v.acc = acc; v.accum = accum; v.lng = lng; v.sgn = sgn;
        v.fl = fl; v.lo = lo; v.hi = hi; v.mf = mf;
        return v;
    endfunction

    // Reference model for 32-bit MUL/MLA.
    function automatic vec_t mk_rand();
        vec_t v;
        v.a     = $urandom;
        v.b     = $urandom;
        v.acc   = $urandom;
        v.accum = 1'($urandom_range(0, 1));
        v.lng   = 1'b0;
        v.sgn   = 1'b0;
        v.fl    = 4'($urandom_range(0, 15));
        v.lo    = v.a * v.b + (v.accum ? v.acc : 32'd0);
        v.hi    = 32'd0;
        v.mf    = {v.lo[31], (v.lo == 32'd0), v.fl[1:0]};
        return v;
    endfunction

    initial begin
        int  bc;
        bit  seen;
        int  dc;
        vec_t v;

        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        last_lo  = '0;
        reset    = 1'b1;
        bus.StartE = 0; bus.FlushE = 0; bus.SrcAE = 0; bus.SrcBE = 0; bus.AccE = 0;
        bus.AccumE = 0; bus.LongE = 0; bus.SignedE = 0; bus.FlagsIn = 0;

        //          a             b             acc    ac lg sg fl       lo            hi            mf
        tbl.push_back(mk(32'd7,        32'd6,        32'd0,  0, 0, 0, 4'b0011, 32'd42,       32'd0,        4'b0011));
        tbl.push_back(mk(32'd0,        32'd5,        32'd0,  0, 0, 0, 4'b0000, 32'd0,        32'd0,        4'b0100));
        tbl.push_back(mk(32'hFFFFFFFF, 32'd2,        32'd0,  0, 0, 0, 4'b0001, 32'hFFFFFFFE, 32'd0,        4'b1001));
        tbl.push_back(mk(32'd3,        32'd4,        32'd10, 1, 0, 0, 4'b0010, 32'd22,       32'd0,        4'b0010));
        tbl.push_back(mk(32'hFFFFFFFF, 32'd1,        32'd1,  1, 0, 0, 4'b1100, 32'd0,        32'd0,        4'b0100));
        tbl.push_back(mk(32'h00010000, 32'h00010000, 32'd0,  0, 0, 0, 4'b0000, 32'd0,        32'd0,        4'b0100));
        tbl.push_back(mk(32'h80000000, 32'd1,        32'd0,  0, 0, 0, 4'b0000, 32'h80000000, 32'd0,        4'b1000));
`ifdef MUL_LONG_EN
        tbl.push_back(mk(32'hFFFFFFFE, 32'd3,        32'd0,  0, 1, 1, 4'b0000, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000));
        tbl.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  0, 1, 0, 4'b0011, 32'h00000001, 32'hFFFFFFFE, 4'b1011));
        tbl.push_back(mk(32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,  0, 1, 1, 4'b0000, 32'd6,        32'd0,        4'b0000));
        tbl.push_back(mk(32'd2,        32'd3,        32'd100,1, 1, 0, 4'b0000, 32'd6,        32'd0,        4'b0000));
        tbl.push_back(mk(32'd0,        32'hFFFFFFFB, 32'd0,  0, 1, 1, 4'b0000, 32'd0,        32'd0,        4'b0100));
`else
        tbl.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  0, 1, 1, 4'b0000, 32'd1,        32'd0,        4'b0000));
        tbl.push_back(mk(32'hFFFFFFFE, 32'd3,        32'd0,  0, 1, 1, 4'b0000, 32'hFFFFFFFA, 32'd0,        4'b1000));
`endif
        for (int r = 0; r < 6; r++) tbl.push_back(mk_rand());

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(bus.Busy),     64'd0);
        chk("rst_done",  64'(bus.Done),     64'd0);
        chk("rst_lo",    64'(bus.ResultLo), 64'd0);
        chk("rst_hi",    64'(bus.ResultHi), 64'd0);
        chk("rst_flags", 64'(bus.MulFlags), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table vectors: latency, single-cycle Done, results via scoreboard
        foreach (tbl[i]) begin
            start_op(tbl[i]);
            wait_done(bc, seen);
            chk("done_seen",   64'(seen), 64'd1);
            chk("busy_cycles", 64'(bc),   64'(NBUSY));
            @(posedge clk); #1;
            chk("done_pulse",  64'(bus.Done), 64'd0);
            chk("idle_busy",   64'(bus.Busy), 64'd0);
        end

        // Flush at RUN cycle 10, with Start in the same cycle
        dc = done_cnt;
        drive_start(mk(32'd9, 32'd9, 32'd0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 4'b0000));
        repeat (9) @(posedge clk);
        #1;
        chk("run_busy", 64'(bus.Busy), 64'd1);
        bus.FlushE = 1'b1;
        bus.StartE = 1'b1;
        @(posedge clk); #1;
        bus.FlushE = 1'b0;
        bus.StartE = 1'b0;
        chk("flush_busy", 64'(bus.Busy),     64'd0);
        chk("flush_hold", 64'(bus.ResultLo), 64'(last_lo));
        // Start together with Flush in IDLE is dropped
        bus.FlushE = 1'b1;
        bus.StartE = 1'b1;
        @(posedge clk); #1;
        bus.FlushE = 1'b0;
        bus.StartE = 1'b0;
        chk("flush_start_busy", 64'(bus.Busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_done", 64'(done_cnt - dc), 64'd0);
        chk("flush_hold2",   64'(bus.ResultLo),  64'(last_lo));

        // Start while busy is ignored
        dc = done_cnt;
        start_op(mk(32'd5, 32'd7, 32'd0, 0, 0, 0, 4'b0001, 32'd35, 32'd0, 4'b0001));
        repeat (4) @(posedge clk);
        #1;
        drive_start(mk(32'd100, 32'd100, 32'd0, 0, 0, 0, 4'b0010, 32'd0, 32'd0, 4'b0000));
        wait_done(bc, seen);
        chk("ign_done_seen", 64'(seen), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("ign_single_done", 64'(done_cnt - dc), 64'd1);

        // Back-to-back: Start in the DONE cycle
        start_op(mk(32'd11, 32'd13, 32'd0, 0, 0, 0, 4'b0000, 32'd143, 32'd0, 4'b0000));
        wait_done(bc, seen);
        chk("b2b_first_seen", 64'(seen), 64'd1);
        start_op(mk(32'd20, 32'd30, 32'd5, 1, 0, 0, 4'b0011, 32'd605, 32'd0, 4'b0011));
        chk("b2b_no_gap", 64'(bus.Busy), 64'd1);
        wait_done(bc, seen);
        chk("b2b_second_seen", 64'(seen), 64'd1);
        chk("b2b_busy_cycles", 64'(bc),   64'(NBUSY));
        @(posedge clk); #1;

        // Reset mid-RUN
        drive_start(mk(32'd3, 32'd3, 32'd0, 0, 0, 0, 4'b0011, 32'd0, 32'd0, 4'b0000));
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_busy",  64'(bus.Busy),     64'd0);
        chk("mrst_done",  64'(bus.Done),     64'd0);
        chk("mrst_lo",    64'(bus.ResultLo), 64'd0);
        chk("mrst_hi",    64'(bus.ResultHi), 64'd0);
        chk("mrst_flags", 64'(bus.MulFlags), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_op(tbl[0]);
        wait_done(bc, seen);
        chk("post_rst_seen", 64'(seen), 64'd1);
        chk("post_rst_busy", 64'(bc),   64'(NBUSY));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
